branch_history_predictor: RTL and testbench
===========================================

// Module: branch_history_predictor
// PURPOSE
//  Per-PC branch direction predictor for the IF stage; successor to the single global
//  saturating counter. Table of ENTRIES counters, CTR_BITS wide, indexed by PC.
//  Bimodal indexing, or gshare (PC XOR global history) when GHR_BITS>0.
//  IF looks up the current PC combinationally; EX writes back resolved outcomes.
//  The lookup index travels down the pipeline with the instruction.
// PARAMETERS
//  ENTRIES   64  table depth; power of 2, >=2; IDX_W = $clog2(ENTRIES)
//  CTR_BITS  2   saturating counter width, 1..4
//  GHR_BITS  0   global history length; 0 = bimodal; 1..IDX_W = gshare
//  PC_LSB    1   lowest PC bit used in the index (1: 16-bit compressed instructions)
// PORTS
//  clk               in   1      clock
//  rst               in   1      synchronous, active-high reset
//  lookup_pc         in   32     PC of the instruction being fetched
//  pred_taken        out  1      MSB of the indexed counter (combinational)
//  pred_index        out  IDX_W  index used for the lookup; carried in pipeline regs
//  update_valid      in   1      resolved conditional branch in EX, not stalled
//  update_index      in   IDX_W  pred_index that travelled with that branch
//  update_taken      in   1      actual branch outcome
//  update_mispredict in   1      predicted direction was wrong
//  branch_count      out  32     resolved branches, saturating
//  mispredict_count  out  32     mispredicted branches, saturating
// BEHAVIOUR
//  - Index: pred_index = lookup_pc[PC_LSB +: IDX_W] ^ {{(IDX_W-GHR_BITS){1'b0}}, ghr}.
//    Bimodal mode has no ghr term.
//  - Lookup latency: 0 cycles, pure combinational read of the table.
//  - Update: effective on the next edge after update_valid=1.
//  - Same-cycle update and lookup of one index: the lookup returns the OLD value. No bypass.
//  - Counter update: taken -> +1, saturates at 2^CTR_BITS-1; not-taken -> -1, saturates at 0.
//  - GHR: updated non-speculatively on update_valid.
//    ghr <= {ghr[GHR_BITS-2:0], update_taken}; GHR_BITS=1 means ghr <= update_taken.
//  - Perf counters: branch_count +1 on update_valid.
//    mispredict_count +1 on update_valid & update_mispredict.
//    Both hold at 32'hFFFF_FFFF. update_mispredict is ignored when update_valid=0.
//  - Reset (one cycle, synchronous): all counters <= WEAK_NT = 2^(CTR_BITS-1)-1; ghr <= 0;
//    both perf counters <= 0. Any reset-cycle update is dropped.
//  - Reset out of reset: pred_taken=0 for every PC; pred_index = lookup_pc index bits.
//  - Reset mid-operation discards all learned state; the next cycle behaves as after power-on.
//  - CTR_BITS=1: WEAK_NT=0, so the counter is a last-outcome bit.
//  - The table is a flop array; no SRAM macro, so the single-cycle clear is possible.
// STRUCTURE
//  - Shared package bp_pkg:
//    * localparam function weak_nt(ctr_bits)
//    * function bp_index(pc, ghr, idx_w, pc_lsb)
//    * CTR_MAX derivation
//  - Sub-module bp_sat_counter #(CTR_BITS) holds one entry; generated ENTRIES times.
//    Ports: clk, rst, inc_en, dec_en, value.
//  - Top level holds the index XOR, GHR shift register, perf counters and write decode.
//  - Elaboration-time checks:
//    * ENTRIES power of 2
//    * GHR_BITS <= IDX_W
//    * 1 <= CTR_BITS <= 4
// TESTING
//  1. Reset: hold rst 2 cycles then release. pred_taken=0 for PCs 0x0, 0x0A, 0xFFFE;
//     both perf counters=0.
//  2. Bimodal, ENTRIES=64, CTR_BITS=2: update idx 5 taken once -> lookup_pc=0x0A gives
//     pred_taken=1. Four more taken, then one not-taken -> still 1. One more not-taken -> 0.
//  3. Aliasing: train idx 5 taken via PC 0x0A -> lookup_pc=0x8A also returns pred_index=5,
//     pred_taken=1.
//  4. Gshare, GHR_BITS=4: updates T,T,N,T -> ghr=4'b1101; lookup_pc=0x0 gives
//     pred_index=6'h0D. Then rst -> pred_index=0.
//  5. Same cycle: update idx 3 taken while lookup maps to idx 3 -> pred_taken=0 that cycle,
//     1 the next cycle.
//  6. Perf counters: 10 updates, 3 with mispredict -> 10/3. 5 update_mispredict pulses with
//     update_valid=0 leave them unchanged. Force branch_count=32'hFFFF_FFFE, apply 3 updates
//     -> 32'hFFFF_FFFF.

Source files
------------

// File: rtl/branch_history_predictor_pkg.sv
// Shared types and helpers for the branch direction predictor: counter limits and index hash.
package bp_pkg;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned PERF_W = 32;

  // Reset value of every counter: the not-taken side, one step below the taken threshold.
  function automatic int unsigned weak_nt(input int unsigned ctr_bits);
    return (32'd1 << (ctr_bits - 32'd1)) - 32'd1;
  endfunction

  function automatic int unsigned ctr_max(input int unsigned ctr_bits);
    return (32'd1 << ctr_bits) - 32'd1;
  endfunction

  // Table index: PC bits above pc_lsb, XORed with the global history in gshare mode.
  function automatic logic [31:0] bp_index(input logic [31:0]  pc,
                                           input logic [31:0]  ghr,
                                           input int unsigned  idx_w,
                                           input int unsigned  pc_lsb);
    logic [31:0] mask;
    mask = (32'd1 << idx_w) - 32'd1;
    return ((pc >> pc_lsb) ^ ghr) & mask;
  endfunction

endpackage

// File: rtl/branch_history_predictor_if.sv
// Lookup/update/perf bundle between the fetch/execute pipeline and the predictor.
interface branch_history_predictor_if
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W = 6
);
  logic [PC_W-1:0]   lookup_pc;
  logic              pred_taken;
  logic [IDX_W-1:0]  pred_index;
  logic              update_valid;
  logic [IDX_W-1:0]  update_index;
  logic              update_taken;
  logic              update_mispredict;
  logic [PERF_W-1:0] branch_count;
  logic [PERF_W-1:0] mispredict_count;

  modport master (
    output lookup_pc, update_valid, update_index, update_taken, update_mispredict,
    input  pred_taken, pred_index, branch_count, mispredict_count
  );

  modport slave (
    input  lookup_pc, update_valid, update_index, update_taken, update_mispredict,
    output pred_taken, pred_index, branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_history_predictor_sat_counter.sv
// One predictor table entry: up/down saturating counter with synchronous clear to weakly-not-taken.
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int unsigned CTR_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc_en,
  input  logic                dec_en,
  output logic [CTR_BITS-1:0] value
);

  localparam logic [CTR_BITS-1:0] CTR_MAX = CTR_BITS'(ctr_max(CTR_BITS));
  localparam logic [CTR_BITS-1:0] WEAK_NT = CTR_BITS'(weak_nt(CTR_BITS));

  logic [CTR_BITS-1:0] value_q;
  logic [CTR_BITS-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (inc_en && (value_q != CTR_MAX)) begin
      value_d = value_q + CTR_BITS'(1);
    end else if (dec_en && (value_q != '0)) begin
      value_d = value_q - CTR_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= WEAK_NT;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/branch_history_predictor.sv
// Per-PC branch direction predictor: bimodal or gshare table of saturating counters,
// combinational lookup for IF, resolved-outcome writeback from EX, saturating perf counters.
module branch_history_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES  = 64,
  parameter int unsigned CTR_BITS = 2,
  parameter int unsigned GHR_BITS = 0,
  parameter int unsigned PC_LSB   = 1
) (
  input logic                         clk,
  input logic                         rst,
  branch_history_predictor_if.slave   bus
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned GHR_W = (GHR_BITS > 0) ? GHR_BITS : 1;

  if ((ENTRIES < 2) || ((ENTRIES & (ENTRIES - 1)) != 0)) begin : g_chk_entries
    $error("branch_history_predictor: ENTRIES must be a power of 2 and >= 2");
  end
  if (GHR_BITS > IDX_W) begin : g_chk_ghr
    $error("branch_history_predictor: GHR_BITS must not exceed IDX_W");
  end
  if ((CTR_BITS < 1) || (CTR_BITS > 4)) begin : g_chk_ctr
    $error("branch_history_predictor: CTR_BITS must be in 1..4");
  end

  logic [GHR_W-1:0]    ghr_q;
  logic [GHR_W-1:0]    ghr_d;
  logic [GHR_W-1:0]    ghr_shift;
  logic [31:0]         ghr_term;
  logic [IDX_W-1:0]    lookup_idx;
  logic [CTR_BITS-1:0] ctr_value [ENTRIES];
  logic [ENTRIES-1:0]  inc_en;
  logic [ENTRIES-1:0]  dec_en;
  logic [PERF_W-1:0]   branch_count_q;
  logic [PERF_W-1:0]   branch_count_d;
  logic [PERF_W-1:0]   mispredict_count_q;
  logic [PERF_W-1:0]   mispredict_count_d;

  // History shift: newest outcome enters at bit 0.
  if (GHR_BITS > 1) begin : g_ghr_shift
    assign ghr_shift = {ghr_q[GHR_W-2:0], bus.update_taken};
  end else begin : g_ghr_bit
    assign ghr_shift = bus.update_taken;
  end

  assign ghr_term   = (GHR_BITS > 0) ? 32'(ghr_q) : 32'd0;
  assign lookup_idx = IDX_W'(bp_index(bus.lookup_pc, ghr_term, IDX_W, PC_LSB));

  // Lookup reads the registered table, so a same-cycle update is not visible yet.
  assign bus.pred_index = lookup_idx;
  assign bus.pred_taken = ctr_value[lookup_idx][CTR_BITS-1];

  for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
    assign inc_en[i] = bus.update_valid && (bus.update_index == IDX_W'(i)) && bus.update_taken;
    assign dec_en[i] = bus.update_valid && (bus.update_index == IDX_W'(i)) && !bus.update_taken;

    bp_sat_counter #(
      .CTR_BITS (CTR_BITS)
    ) u_ctr (
      .clk    (clk),
      .rst    (rst),
      .inc_en (inc_en[i]),
      .dec_en (dec_en[i]),
      .value  (ctr_value[i])
    );
  end

  always_comb begin
    ghr_d              = ghr_q;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (bus.update_valid) begin
      ghr_d = ghr_shift;
      if (branch_count_q != '1) begin
        branch_count_d = branch_count_q + PERF_W'(1);
      end
      if (bus.update_mispredict && (mispredict_count_q != '1)) begin
        mispredict_count_d = mispredict_count_q + PERF_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q              <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      ghr_q              <= ghr_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign bus.branch_count     = branch_count_q;
  assign bus.mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_history_predictor.sv
// Scoreboard bench: a bimodal and a gshare predictor share one stimulus stream and are
// checked every cycle against an array-based reference model.
module tb_branch_history_predictor;
  import bp_pkg::*;

  localparam int unsigned ENTRIES  = 64;
  localparam int unsigned CTR_BITS = 2;
  localparam int unsigned PC_LSB   = 1;
  localparam int unsigned IDX_W    = 6;
  localparam int unsigned GS_BITS  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_history_predictor_if #(.IDX_W(IDX_W)) bi_if ();
  branch_history_predictor_if #(.IDX_W(IDX_W)) gs_if ();

  branch_history_predictor #(
    .ENTRIES(ENTRIES), .CTR_BITS(CTR_BITS), .GHR_BITS(0), .PC_LSB(PC_LSB)
  ) dut_bi (
    .clk(clk), .rst(rst), .bus(bi_if.slave)
  );

  branch_history_predictor #(
    .ENTRIES(ENTRIES), .CTR_BITS(CTR_BITS), .GHR_BITS(GS_BITS), .PC_LSB(PC_LSB)
  ) dut_gs (
    .clk(clk), .rst(rst), .bus(gs_if.slave)
  );

  typedef struct {
    bit          chk;
    logic        pt [2];
    logic [5:0]  pi [2];
    logic [31:0] bc [2];
    logic [31:0] mc [2];
    int          k_pt;
    int          k_pi_bi;
    int          k_pi_gs;
  } exp_t;

  exp_t q_exp [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: model 0 is bimodal, model 1 keeps a 4-bit outcome history.
  int unsigned     m_ctr [2][ENTRIES];
  int unsigned     m_ghr [2];
  longint unsigned m_bc  [2];
  longint unsigned m_mc  [2];

  function automatic int unsigned m_idx(input int m, input logic [31:0] pc);
    return ((pc >> PC_LSB) % ENTRIES) ^ m_ghr[m];
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int e = 0; e < int'(ENTRIES); e++) m_ctr[m][e] = (1 << (CTR_BITS - 1)) - 1;
      m_ghr[m] = 0;
      m_bc[m]  = 0;
      m_mc[m]  = 0;
    end
  endtask

  task automatic model_update(input int unsigned idx, input bit t, input bit mp);
    for (int m = 0; m < 2; m++) begin
      if (t && m_ctr[m][idx] < (1 << CTR_BITS) - 1) m_ctr[m][idx]++;
      if (!t && m_ctr[m][idx] > 0)                  m_ctr[m][idx]--;
      if (m == 1) m_ghr[m] = ((m_ghr[m] << 1) | int'(t)) % (1 << GS_BITS);
      if (m_bc[m] < 64'hFFFF_FFFF)        m_bc[m]++;
      if (mp && m_mc[m] < 64'hFFFF_FFFF)  m_mc[m]++;
    end
  endtask

  // Drive one cycle, queue what the outputs must show before the coming edge, advance the model.
  task automatic step(input bit r, input logic [31:0] pc, input bit v, input logic [5:0] idx,
                      input bit t, input bit mp, input bit chk = 1'b1,
                      input int k_pt = -1, input int k_pi_bi = -1, input int k_pi_gs = -1);
    exp_t e;
    rst = r;
    bi_if.lookup_pc = pc;          gs_if.lookup_pc = pc;
    bi_if.update_valid = v;        gs_if.update_valid = v;
    bi_if.update_index = idx;      gs_if.update_index = idx;
    bi_if.update_taken = t;        gs_if.update_taken = t;
    bi_if.update_mispredict = mp;  gs_if.update_mispredict = mp;
    e.chk = chk;
    for (int m = 0; m < 2; m++) begin
      e.pt[m] = (m_ctr[m][m_idx(m, pc)] >= (1 << (CTR_BITS - 1)));
      e.pi[m] = 6'(m_idx(m, pc));
      e.bc[m] = 32'(m_bc[m]);
      e.mc[m] = 32'(m_mc[m]);
    end
    e.k_pt = k_pt; e.k_pi_bi = k_pi_bi; e.k_pi_gs = k_pi_gs;
    q_exp.push_back(e);
    if (r)      model_reset();
    else if (v) model_update(int'(idx), t, mp);
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: outputs are settled mid-cycle; pop the entry queued for this cycle.
  always @(negedge clk) begin
    if (q_exp.size() > 0) begin
      exp_t e;
      e = q_exp.pop_front();
      if (e.chk) begin
        cmp("bi_pred_taken",  32'(bi_if.pred_taken),  32'(e.pt[0]));
        cmp("bi_pred_index",  32'(bi_if.pred_index),  32'(e.pi[0]));
        cmp("bi_branch_cnt",  bi_if.branch_count,     e.bc[0]);
        cmp("bi_mispred_cnt", bi_if.mispredict_count, e.mc[0]);
        cmp("gs_pred_taken",  32'(gs_if.pred_taken),  32'(e.pt[1]));
        cmp("gs_pred_index",  32'(gs_if.pred_index),  32'(e.pi[1]));
        cmp("gs_branch_cnt",  gs_if.branch_count,     e.bc[1]);
        cmp("gs_mispred_cnt", gs_if.mispredict_count, e.mc[1]);
        if (e.k_pt >= 0)    cmp("bi_pred_taken_directed", 32'(bi_if.pred_taken), 32'(e.k_pt));
        if (e.k_pi_bi >= 0) cmp("bi_pred_index_directed", 32'(bi_if.pred_index), 32'(e.k_pi_bi));
        if (e.k_pi_gs >= 0) cmp("gs_pred_index_directed", 32'(gs_if.pred_index), 32'(e.k_pi_gs));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] pc;
    logic [5:0]  idx;
    rst = 1'b1;
    bi_if.lookup_pc = '0; bi_if.update_valid = 1'b0; bi_if.update_index = '0;
    bi_if.update_taken = 1'b0; bi_if.update_mispredict = 1'b0;
    gs_if.lookup_pc = '0; gs_if.update_valid = 1'b0; gs_if.update_index = '0;
    gs_if.update_taken = 1'b0; gs_if.update_mispredict = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    // Reset held two cycles, then cold lookups.
    step(1, 32'h0, 0, 0, 0, 0, 1'b0);
    step(1, 32'h0, 0, 0, 0, 0);
    step(0, 32'h0000_0000, 0, 0, 0, 0, 1'b1, 0, 0);
    step(0, 32'h0000_000A, 0, 0, 0, 0, 1'b1, 0, 5);
    step(0, 32'h0000_FFFE, 0, 0, 0, 0, 1'b1, 0, 63);

    // Bimodal training on index 5 via PC 0x0A.
    step(0, 32'h0A, 1, 6'd5, 1, 0, 1'b1, 0);
    step(0, 32'h0A, 0, 0, 0, 0, 1'b1, 1);
    for (int i = 0; i < 4; i++) step(0, 32'h0A, 1, 6'd5, 1, 0);
    step(0, 32'h0A, 1, 6'd5, 0, 1);
    step(0, 32'h0A, 0, 0, 0, 0, 1'b1, 1);
    step(0, 32'h0A, 1, 6'd5, 0, 1);
    step(0, 32'h0A, 0, 0, 0, 0, 1'b1, 0);

    // Aliasing: PC 0x8A lands on the same bimodal entry.
    step(0, 32'h0A, 1, 6'd5, 1, 0);
    step(0, 32'h0A, 1, 6'd5, 1, 0);
    step(0, 32'h8A, 0, 0, 0, 0, 1'b1, 1, 5);

    // Gshare history T,T,N,T then reset clears it.
    step(1, 32'h0, 0, 0, 0, 0);
    step(0, 32'h0, 1, 6'd0, 1, 0);
    step(0, 32'h0, 1, 6'd0, 1, 0);
    step(0, 32'h0, 1, 6'd0, 0, 0);
    step(0, 32'h0, 1, 6'd0, 1, 0);
    step(0, 32'h0, 0, 0, 0, 0, 1'b1, -1, 0, 8'h0D);
    step(1, 32'h0, 0, 0, 0, 0);
    step(0, 32'h0, 0, 0, 0, 0, 1'b1, 0, 0, 0);

    // Same-cycle update and lookup of index 3: old value first, new value next cycle.
    step(0, 32'h06, 1, 6'd3, 1, 0, 1'b1, 0, 3);
    step(0, 32'h06, 0, 0, 0, 0, 1'b1, 1, 3);

    // Perf counters: 10 updates with 3 mispredicts, then ignored mispredict pulses.
    step(1, 32'h0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 32'h10, 1, 6'(i), i[0], (i % 3) == 0 && i < 9);
    for (int i = 0; i < 5; i++)  step(0, 32'h10, 0, 6'(i), 1, 1);
    step(0, 32'h10, 0, 0, 0, 0);

    // Saturation of the bimodal branch counter from 0xFFFF_FFFE.
    force dut_bi.branch_count_d = 32'hFFFF_FFFE;
    step(0, 32'h10, 0, 0, 0, 0);
    release dut_bi.branch_count_d;
    m_bc[0] = 64'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) step(0, 32'h10, 1, 6'd9, 1, 0);
    step(0, 32'h10, 0, 0, 0, 0);

    // Randomized traffic with occasional mid-run reset and same-index collisions.
    for (int i = 0; i < 2000; i++) begin
      pc  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_01FE);
      idx = ($urandom_range(0, 4) == 0) ? 6'(m_idx(0, pc)) : 6'($urandom);
      step($urandom_range(0, 199) == 0, pc, $urandom_range(0, 3) != 0, idx,
           $urandom_range(0, 99) < 65, $urandom_range(0, 3) == 0);
    end

    step(0, 32'h0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
